// File: rtl/serial_parity_pkg.sv
// Shared definitions for the XOR-parity serial link: receiver FSM states,
// default link parameters and the parity rule used by both link ends.
package serial_parity_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Parity bit a transmitter appends; callers zero-extend narrower words.
    function automatic logic parity_bit(input logic [63:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter bit RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, LSB-first data, XOR parity, stop.
// Reports every completed frame with parity and framing status.
module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int H     = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par, par_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, parity_err_n, frame_err_n;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            par        <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shift      <= shift_n;
            par        <= par_n;
            data       <= data_n;
            valid      <= valid_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        idx_n        = idx;
        shift_n      = shift;
        par_n        = par;
        data_n       = data;
        valid_n      = 1'b0;
        parity_err_n = parity_err;
        frame_err_n  = frame_err;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end

            // Re-check the start bit near its centre to reject glitches.
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        idx_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n          = '0;
                    shift_n[idx]   = rx_s;
                    if (idx == IDX_LAST) begin
                        state_n = PARITY;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    par_n   = rx_s;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            // Publish at mid-stop so a new start edge can be caught right away.
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n        = '0;
                    data_n       = shift;
                    parity_err_n = parity_bit(64'(shift), PARITY_ODD) ^ par;
                    frame_err_n  = ~rx_s;
                    valid_n      = 1'b1;
                    state_n      = rx_s ? IDLE : BREAK;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
